pipe_stage_reg: RTL

Parametrised pipeline stage register, the successor to the fixed EX/MEM latch. It carries an opaque data bundle and a control bundle between two pipeline stages using a valid/ready handshake. It supports backpressure (stall), flush (bubble insertion on branch/exception) and an optional 1-entry skid buffer that keeps full throughput. It also provides saturating stall and bubble counters for performance monitoring. It is instantiated for the IF/ID, ID/EX, EX/MEM and MEM/WB boundaries.

---
 rtl/pipe_pkg.sv | 35 +++
 rtl/pipe_stage_reg_sat_counter.sv | 30 +++
 rtl/pipe_stage_reg.sv | 122 ++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: EX/MEM control bit positions, default widths
// and the data/control bundle widths of each pipeline boundary.
package pipe_pkg;

  localparam int PC_W       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int WORD_W     = 32;

  localparam int CTRL_MEMREAD  = 0;
  localparam int CTRL_MEMWRITE = 1;
  localparam int CTRL_REGWRITE = 2;
  localparam int CTRL_MEMTOREG = 3;
  localparam int CTRL_BRANCH   = 4;
  localparam int CTRL_ZERO     = 5;

  // Bundle widths per boundary; EX/MEM carries PC, ALU result, RD2 and wn.
  localparam int IFID_DATA_W  = PC_W + WORD_W;
  localparam int IFID_CTRL_W  = 1;
  localparam int IDEX_DATA_W  = PC_W + 3 * WORD_W + 2 * REG_ADDR_W;
  localparam int IDEX_CTRL_W  = 8;
  localparam int EXMEM_DATA_W = PC_W + 2 * WORD_W + REG_ADDR_W;
  localparam int EXMEM_CTRL_W = 6;
  localparam int MEMWB_DATA_W = 2 * WORD_W + REG_ADDR_W;
  localparam int MEMWB_CTRL_W = 2;

  typedef struct packed {
    logic zero;
    logic branch;
    logic memtoreg;
    logic regwrite;
    logic memwrite;
    logic memread;
  } exmem_ctrl_t;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter used for the stage's stall and bubble statistics.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with optional skid entry, flush and
// saturating stall/bubble counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = EXMEM_DATA_W,
  parameter int CTRL_W = EXMEM_CTRL_W,
  parameter bit SKID   = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic              in_fire, out_fire;

  // With the skid entry, in_ready depends only on state, breaking the ready chain.
  assign in_ready = SKID ? !skid_valid_q : (!out_valid_q || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    main_data_d  = main_data_q;
    main_ctrl_d  = main_ctrl_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_ctrl_d  = skid_ctrl_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      main_ctrl_d  = '0;
      skid_valid_d = 1'b0;
      skid_ctrl_d  = '0;
    end else if (!SKID) begin
      if (in_fire) begin
        out_valid_d = 1'b1;
        main_data_d = in_data;
        main_ctrl_d = in_ctrl;
      end else if (out_fire) begin
        out_valid_d = 1'b0;
        main_ctrl_d = '0;
      end
    end else if (!out_valid_q) begin
      if (in_fire) begin
        out_valid_d = 1'b1;
        main_data_d = in_data;
        main_ctrl_d = in_ctrl;
      end
    end else if (out_ready) begin
      // Skid holds the older bundle, so it must drain before new input.
      if (skid_valid_q) begin
        main_data_d  = skid_data_q;
        main_ctrl_d  = skid_ctrl_q;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        main_data_d = in_data;
        main_ctrl_d = in_ctrl;
      end else begin
        out_valid_d = 1'b0;
        main_ctrl_d = '0;
      end
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
      skid_ctrl_d  = in_ctrl;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      main_data_q  <= '0;
      main_ctrl_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_ctrl_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      main_data_q  <= main_data_d;
      main_ctrl_q  <= main_ctrl_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_ctrl_q  <= skid_ctrl_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = main_data_q;
  assign out_ctrl  = main_ctrl_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (out_valid_q && !out_ready),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (!out_valid_q && out_ready),
    .count (bubble_cnt)
  );

endmodule
